// File: rtl/inv_normalize_if.sv
// Handshake and operand bundle between the Gauss-Jordan inverse stage, the
// normaliser and its downstream consumer.
interface inv_normalize_if #(
    parameter int W = 32,
    parameter int N = 5
);
    logic               start;
    logic [N*N*W-1:0]   num_flat;
    logic [N*W-1:0]     piv_flat;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [4:0]         out_index;
    logic               done;
    logic               singular;

    modport master (
        output start, num_flat, piv_flat, out_ready,
        input  busy, out_valid, out_data, out_index, done, singular
    );

    modport slave (
        input  start, num_flat, piv_flat, out_ready,
        output busy, out_valid, out_data, out_index, done, singular
    );
endinterface

// File: rtl/inv_normalize.sv
// Divides each entry of an unnormalised 5x5 inverse by its row pivot using a
// sequential restoring divider; streams signed Q(W-FRAC).FRAC results row-major.
module inv_normalize #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int N    = 5
) (
    input  logic           clk,
    input  logic           reset,
    inv_normalize_if.slave bus
);
    localparam int QW = W + FRAC;
    localparam int CW = $clog2(QW);
    localparam int RW = $clog2(N);
    localparam int KW = 5;

    localparam logic [QW-1:0] POS_MAX = {{(FRAC + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [QW-1:0] NEG_MAG = {{FRAC{1'b0}}, 1'b1, {(W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CHECK, SETUP, DIV, FIX, OUT, FINISH} state_t;

    state_t        state, state_next;
    logic [W-1:0]  num_r [N*N];
    logic [W-1:0]  piv_r [N];
    logic [KW-1:0] k;
    logic [RW-1:0] row, col;
    logic [CW-1:0] cnt;
    logic [QW-1:0] dq;
    logic [W-1:0]  rem, dvs;
    logic          neg;
    logic [W-1:0]  out_data_r;
    logic [KW-1:0] out_index_r;
    logic          singular_r;

    logic          any_zero, last;
    logic [W-1:0]  num_sel, piv_sel, num_mag, piv_mag, fix_val;
    logic [W:0]    rem_shift;

    // Unsigned W-bit magnitudes hold 2^(W-1) exactly, so the most negative input needs no special case.
    always_comb begin
        num_sel   = num_r[k];
        piv_sel   = piv_r[row];
        num_mag   = num_sel[W-1] ? (~num_sel + W'(1)) : num_sel;
        piv_mag   = piv_sel[W-1] ? (~piv_sel + W'(1)) : piv_sel;
        rem_shift = {rem, dq[QW-1]};
        last      = (k == KW'(N * N - 1));
        any_zero  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (piv_r[i] == '0) any_zero = 1'b1;
        end
    end

    // Sign is applied after division, so the result truncates toward zero before saturation.
    always_comb begin
        fix_val = dq[W-1:0];
        if (neg) begin
            if (dq >= NEG_MAG) fix_val = {1'b1, {(W - 1){1'b0}}};
            else               fix_val = -dq[W-1:0];
        end else if (dq > POS_MAX) begin
            fix_val = {1'b0, {(W - 1){1'b1}}};
        end
    end

    // NOTE: reset is synchronous and active-high, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CHECK;
            CHECK:   state_next = any_zero ? IDLE : SETUP;
            SETUP:   state_next = DIV;
            DIV:     if (cnt == '0) state_next = FIX;
            FIX:     state_next = OUT;
            OUT:     if (bus.out_ready) state_next = last ? FINISH : SETUP;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE) && (state != FINISH);
        bus.out_valid = (state == OUT);
        bus.done      = (state == FINISH);
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_index = out_index_r;
    assign bus.singular  = singular_r;

    // NOTE: captured operands are plain data qualified by the FSM, so this storage carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            for (int i = 0; i < N * N; i++) num_r[i] <= bus.num_flat[i*W +: W];
            for (int i = 0; i < N; i++)     piv_r[i] <= bus.piv_flat[i*W +: W];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r  <= '0;
            out_index_r <= '0;
            singular_r  <= 1'b0;
            k           <= '0;
            row         <= '0;
            col         <= '0;
            cnt         <= '0;
            dq          <= '0;
            rem         <= '0;
            dvs         <= '0;
            neg         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    singular_r <= 1'b0;
                    k          <= '0;
                    row        <= '0;
                    col        <= '0;
                end
                CHECK: if (any_zero) singular_r <= 1'b1;
                SETUP: begin
                    dq  <= {num_mag, {FRAC{1'b0}}};
                    rem <= '0;
                    dvs <= piv_mag;
                    neg <= num_sel[W-1] ^ piv_sel[W-1];
                    cnt <= CW'(QW - 1);
                end
                DIV: begin
                    // Dividend bits shift out of dq's top while quotient bits enter at the bottom.
                    if (rem_shift >= {1'b0, dvs}) begin
                        rem <= rem_shift[W-1:0] - dvs;
                        dq  <= {dq[QW-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[W-1:0];
                        dq  <= {dq[QW-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    out_data_r  <= fix_val;
                    out_index_r <= k;
                end
                OUT: if (bus.out_ready && !last) begin
                    k <= k + KW'(1);
                    if (col == RW'(N - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_normalize.sv
// Scoreboard bench for inv_normalize: directed matrices with hand-computed
// quotients, checked by a monitor that pops expectations on each accepted beat.
module tb_inv_normalize;
    localparam int W  = 32;
    localparam int N  = 5;
    localparam int NE = N * N;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inv_normalize_if #(.W(W), .N(N)) bus();
    inv_normalize #(.W(W), .FRAC(16), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          idx;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] num_a [NE];
    logic [31:0] piv_a [N];
    logic [31:0] exp_a [NE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!reset) begin
            if (bus.done) done_cnt++;
            if (bus.out_valid) check("valid_while_singular", bus.singular, 0);
            if (bus.out_valid && bus.out_ready) begin
                beat_cnt++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_index k=%0d", e.idx), bus.out_index, e.idx);
                    check($sformatf("beat_data k=%0d", e.idx), bus.out_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vec();
        for (int i = 0; i < NE; i++) begin
            num_a[i] = '0;
            exp_a[i] = '0;
        end
        for (int i = 0; i < N; i++) piv_a[i] = 32'd1;
    endtask

    task automatic set_identity();
        clear_vec();
        for (int r = 0; r < N; r++) begin
            num_a[r*6] = 32'd1;
            exp_a[r*6] = 32'h0001_0000;
        end
    endtask

    task automatic set_scaling();
        clear_vec();
        piv_a[0] = 32'd4;         piv_a[1] = 32'hFFFF_FFFE; piv_a[2] = 32'd3;
        num_a[0]  = 32'd1;        exp_a[0]  = 32'h0000_4000;
        num_a[1]  = 32'hFFFF_FFFD; exp_a[1] = 32'hFFFF_4000;
        num_a[2]  = 32'd2;        exp_a[2]  = 32'h0000_8000;
        num_a[5]  = 32'd3;        exp_a[5]  = 32'hFFFE_8000;
        num_a[6]  = 32'hFFFF_FFFD; exp_a[6] = 32'h0001_8000;
        num_a[7]  = 32'd5;        exp_a[7]  = 32'hFFFD_8000;
        num_a[12] = 32'd1;        exp_a[12] = 32'h0000_5555;
        num_a[13] = 32'hFFFF_FFFF; exp_a[13] = 32'hFFFF_AAAB;
        num_a[18] = 32'd100;      exp_a[18] = 32'h0064_0000;
        num_a[24] = 32'hFFFF_FFF9; exp_a[24] = 32'hFFF9_0000;
    endtask

    task automatic set_saturation();
        clear_vec();
        piv_a[1] = 32'hFFFF_FFFF; piv_a[3] = 32'h8000_0000;
        num_a[0]  = 32'h7FFF_FFFF; exp_a[0]  = 32'h7FFF_FFFF;
        num_a[1]  = 32'h8000_0000; exp_a[1]  = 32'h8000_0000;
        num_a[5]  = 32'h8000_0000; exp_a[5]  = 32'h7FFF_FFFF;
        num_a[6]  = 32'h0000_8000; exp_a[6]  = 32'h8000_0000;
        num_a[7]  = 32'hFFFF_8000; exp_a[7]  = 32'h7FFF_FFFF;
        num_a[10] = 32'h0000_7FFF; exp_a[10] = 32'h7FFF_0000;
        num_a[11] = 32'hFFFF_8000; exp_a[11] = 32'h8000_0000;
        num_a[15] = 32'h8000_0000; exp_a[15] = 32'h0001_0000;
        num_a[16] = 32'h4000_0000; exp_a[16] = 32'hFFFF_8000;
        num_a[17] = 32'd1;         exp_a[17] = 32'h0000_0000;
    endtask

    task automatic issue_start();
        for (int i = 0; i < NE; i++) bus.num_flat[i*W +: W] = num_a[i];
        for (int i = 0; i < N; i++)  bus.piv_flat[i*W +: W] = piv_a[i];
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.num_flat = {NE{32'hDEAD_BEEF}};
        bus.piv_flat = '0;
    endtask

    task automatic begin_run(input string tag);
        exp_q.delete();
        beat_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < NE; i++) exp_q.push_back('{idx: i, data: exp_a[i]});
        issue_start();
        check({tag, " busy_after_start"}, bus.busy, 1);
        check({tag, " singular_cleared"}, bus.singular, 0);
        check({tag, " no_valid_in_check"}, bus.out_valid, 0);
    endtask

    // glitch_at >= 0 pulses start that many negedges into the run while busy.
    task automatic finish_run(input string tag, input bit exact, input int glitch_at);
        bit ok = 1'b0;
        int cyc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == glitch_at)     bus.start = 1'b1;
            if (i == glitch_at + 1) bus.start = 1'b0;
            if (bus.done) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
        end
        bus.start = 1'b0;
        check({tag, " done_seen"}, ok, 1);
        check({tag, " busy_low_at_done"}, bus.busy, 0);
        if (exact) check({tag, " cycles_to_done"}, cyc, 1276);
        tick(); tick(); tick();
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " beats"}, beat_cnt, NE);
        check({tag, " scoreboard_empty"}, exp_q.size(), 0);
        check({tag, " singular"}, bus.singular, 0);
    endtask

    task automatic wait_beat(input string tag, input int idx);
        bit found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_index == 5'(idx)) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, " beat_reached"}, found, 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        bit found;
        int lat;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        bus.num_flat  = '0;
        bus.piv_flat  = '0;
        reset = 1'b1;
        tick(); tick(); tick();
        check("reset busy", bus.busy, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_data", bus.out_data, 0);
        check("reset out_index", bus.out_index, 0);
        check("reset done", bus.done, 0);
        check("reset singular", bus.singular, 0);
        reset = 1'b0;
        tick();

        set_identity();
        begin_run("identity");
        finish_run("identity", 1'b1, -1);

        set_scaling();
        begin_run("scale");
        finish_run("scale", 1'b1, -1);

        set_saturation();
        begin_run("saturate");
        finish_run("saturate", 1'b1, -1);

        // Zero pivot: flagged after the CHECK cycle, no beats at all.
        set_identity();
        piv_a[2] = '0;
        exp_q.delete();
        beat_cnt = 0;
        issue_start();
        check("singular busy_in_check", bus.busy, 1);
        check("singular not_yet", bus.singular, 0);
        tick();
        check("singular set", bus.singular, 1);
        check("singular busy_dropped", bus.busy, 0);
        check("singular no_done", bus.done, 0);
        repeat (60) @(negedge clk);
        check("singular no_beats", beat_cnt, 0);
        check("singular sticky", bus.singular, 1);

        set_identity();
        begin_run("recover");
        finish_run("recover", 1'b1, -1);

        // Backpressure on entry 7, then entry-8 latency from the handshake.
        set_scaling();
        begin_run("bp");
        wait_beat("bp k6", 6);
        tick();
        bus.out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("bp k7_valid", found, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold_valid", bus.out_valid, 1);
            check("bp hold_index", bus.out_index, 7);
            check("bp hold_data", bus.out_data, 32'hFFFD_8000);
        end
        tick();
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) break;
        end
        check("bp k8_latency", lat, 50);
        finish_run("bp", 1'b0, -1);

        // Reset while dividing entry 3 aborts; a fresh start begins at k=0.
        set_scaling();
        begin_run("rst");
        wait_beat("rst k2", 2);
        tick();
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check("mid_reset busy", bus.busy, 0);
        check("mid_reset out_valid", bus.out_valid, 0);
        check("mid_reset out_data", bus.out_data, 0);
        check("mid_reset out_index", bus.out_index, 0);
        check("mid_reset done", bus.done, 0);
        check("mid_reset singular", bus.singular, 0);
        reset = 1'b0;
        tick();
        set_scaling();
        begin_run("post_reset");
        finish_run("post_reset", 1'b1, -1);

        // A start pulse while busy is ignored.
        set_identity();
        begin_run("busy_start");
        finish_run("busy_start", 1'b1, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
